// File: rtl/decrypt_unit_if.sv
// rtl/decrypt_unit_if.sv - handshake/bus bundle for decrypt_unit
// Purpose: groups the input (stored/key/tag) and output (result/errors) channels.
// Ports (as seen by the unit, modport slave):
//   in_valid/in_ready   input handshake, stored[7:0], key[3:0], tag_in[TAG_W-1:0]
//   out_valid/out_ready output handshake, num_out[3:0], tag_out[TAG_W-1:0],
//   err_div0, err_ovf, err_rem
interface decrypt_unit_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       stored;
  logic [3:0]       key;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       num_out;
  logic [TAG_W-1:0] tag_out;
  logic             err_div0;
  logic             err_ovf;
  logic             err_rem;

  modport master (
    output in_valid, stored, key, tag_in, out_ready,
    input  in_ready, out_valid, num_out, tag_out, err_div0, err_ovf, err_rem
  );

  modport slave (
    input  in_valid, stored, key, tag_in, out_ready,
    output in_ready, out_valid, num_out, tag_out, err_div0, err_ovf, err_rem
  );
endinterface

// File: rtl/decrypt_unit.sv
// rtl/decrypt_unit.sv - recovers a 4-bit number from stored word / key, then un-rotates
// Purpose: restoring division of an 8-bit stored word by a 4-bit key (one quotient
//   bit per clock), followed by a right rotation that undoes the upstream left rotation.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    decrypt_unit_if.slave (input channel, result channel, error flags)
module decrypt_unit #(
  parameter int ROT_AMT = 1,
  parameter int TAG_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  decrypt_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    UNROT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       lo_q;     // low dividend nibble, fed in one bit per DIV step
  logic [3:0]       key_q;
  logic [TAG_W-1:0] tag_q;
  logic [4:0]       rem;
  logic [3:0]       q;
  logic [1:0]       cnt;

  logic [4:0]       r_shift;
  logic [4:0]       r_sub;
  logic             r_ge;
  logic [3:0]       q_rot;

  assign bus.in_ready = (state == IDLE);

  // Partial remainder stays below key, so shifting in one bit never needs more than 5 bits.
  assign r_shift = {rem[3:0], lo_q[cnt]};
  assign r_ge    = (r_shift >= {1'b0, key_q});
  assign r_sub   = r_shift - {1'b0, key_q};

  // Right rotation: the low nibble of {q,q} shifted right by ROT_AMT.
  assign q_rot = 4'({q, q} >> ROT_AMT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.out_valid <= 1'b0;
      bus.num_out  <= 4'd0;
      bus.tag_out  <= '0;
      bus.err_div0 <= 1'b0;
      bus.err_ovf  <= 1'b0;
      bus.err_rem  <= 1'b0;
      lo_q         <= 4'd0;
      key_q        <= 4'd0;
      tag_q        <= '0;
      rem          <= 5'd0;
      q            <= 4'd0;
      cnt          <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            lo_q  <= bus.stored[3:0];
            key_q <= bus.key;
            tag_q <= bus.tag_in;
            if (bus.key == 4'd0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.num_out   <= 4'd0;
              bus.tag_out   <= bus.tag_in;
              bus.err_div0  <= 1'b1;
              bus.err_ovf   <= 1'b0;
              bus.err_rem   <= 1'b0;
            end else if (bus.stored[7:4] >= bus.key) begin
              // Quotient would need a fifth bit.
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.num_out   <= 4'd0;
              bus.tag_out   <= bus.tag_in;
              bus.err_div0  <= 1'b0;
              bus.err_ovf   <= 1'b1;
              bus.err_rem   <= 1'b0;
            end else begin
              rem   <= {1'b0, bus.stored[7:4]};
              cnt   <= 2'd3;
              state <= DIV;
            end
          end
        end

        DIV: begin
          if (r_ge) begin
            rem    <= r_sub;
            q[cnt] <= 1'b1;
          end else begin
            rem    <= r_shift;
            q[cnt] <= 1'b0;
          end
          if (cnt == 2'd0) begin
            state <= UNROT;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        UNROT: begin
          state         <= DONE;
          bus.out_valid <= 1'b1;
          bus.num_out   <= q_rot;
          bus.tag_out   <= tag_q;
          bus.err_div0  <= 1'b0;
          bus.err_ovf   <= 1'b0;
          bus.err_rem   <= (rem != 5'd0);
        end

        DONE: begin
          // Result fields stay as they are after the handshake; only out_valid drops.
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
